led_matrix_scanner: RTL and testbench

Parametrised row-scanning driver for a multiplexed LED matrix, sitting between game logic (which produces a flat pixel framebuffer) and the board's row/column pins. It has the following features:
- Programmable row dwell time.
- Anti-ghosting blanking between rows.
- A double-buffered framebuffer that swaps only at frame boundaries, so frames never tear.
- A frame-start strobe for the game logic.

---
 rtl/led_matrix_pkg.sv | 17 +
 rtl/led_scan_timer.sv | 54 +++++
 rtl/led_matrix_scanner.sv | 116 +++++++++++
 tb/tb_led_matrix_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared defaults, counter-width helper and brightness width for the LED matrix scanner.
package led_matrix_pkg;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_SCAN_DIV     = 1024;
  localparam int DEF_BLANK_CYCLES = 16;
  localparam int BRIGHT_W         = 4;

  // Ceiling log2 with a floor of 1 so a counter never collapses to zero bits.
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/row timebase: tick counts cycles within a row slot, row_idx walks the rows.
module led_scan_timer import led_matrix_pkg::*; #(
  parameter int ROWS         = DEF_ROWS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int TICK_W       = clog2(SCAN_DIV),
  parameter int ROW_W        = clog2(ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic [TICK_W-1:0] o_tick,
  output logic              o_slot_start,
  output logic              o_blank,
  output logic              o_frame_end
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [TICK_W:0]   BLANK_Q   = (TICK_W + 1)'(BLANK_CYCLES);

  logic              r_run;
  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row;
  logic              w_tick_wrap;

  assign w_tick_wrap = (r_tick == TICK_LAST);

  // The first cycle out of reset parks at (0,0) so the scan starts one edge later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run  <= 1'b0;
      r_tick <= '0;
      r_row  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_tick_wrap) begin
          r_tick <= '0;
          r_row  <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  assign o_row_idx    = r_row;
  assign o_tick       = r_tick;
  assign o_slot_start = r_run && (r_tick == '0);
  assign o_blank      = !r_run || ({1'b0, r_tick} < BLANK_Q);
  assign o_frame_end  = r_run && w_tick_wrap && (r_row == ROW_LAST);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning LED matrix driver with double-buffered framebuffer and blanking.
// Optional per-row PWM dimming is enabled by defining LED_SCAN_PWM_EN.
module led_matrix_scanner import led_matrix_pkg::*; #(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] fb_in,
  input  logic                 fb_load,
`ifdef LED_SCAN_PWM_EN
  input  logic [BRIGHT_W-1:0]  brightness,
`endif
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic                 frame_start
);

  localparam int ROW_W  = clog2(ROWS);
  localparam int TICK_W = clog2(SCAN_DIV);

  logic [ROW_W-1:0]     w_row_idx;
  logic [TICK_W-1:0]    w_tick;
  logic                 w_slot_start;
  logic                 w_blank;
  logic                 w_frame_end;
  logic                 w_unused_tick;
  logic                 w_pwm_on;
  logic [ROWS-1:0]      w_row_onehot;
  logic [COLS-1:0]      w_row_bits;

  logic [ROWS*COLS-1:0] r_pending;
  logic                 r_pending_valid;
  logic [ROWS*COLS-1:0] r_shadow;

  led_scan_timer #(
    .ROWS         (ROWS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .TICK_W       (TICK_W),
    .ROW_W        (ROW_W)
  ) u_timer (
    .i_clk        (system_clk),
    .i_rst        (rst),
    .o_row_idx    (w_row_idx),
    .o_tick       (w_tick),
    .o_slot_start (w_slot_start),
    .o_blank      (w_blank),
    .o_frame_end  (w_frame_end)
  );

  assign w_unused_tick = ^w_tick;

  // Swap uses the old pending contents; a load on the same edge becomes the next pending frame.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_shadow        <= '0;
    end else begin
      if (w_frame_end && r_pending_valid) r_shadow <= r_pending;
      if (fb_load) begin
        r_pending       <= fb_in;
        r_pending_valid <= 1'b1;
      end else if (w_frame_end) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

`ifdef LED_SCAN_PWM_EN
  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic [BRIGHT_W-1:0] r_bright_q;
  logic [BRIGHT_W-1:0] w_pwm_cur;

  // The count seen on a slot's first tick is always zero, even with no blanking.
  assign w_pwm_cur = w_slot_start ? '0 : r_pwm_cnt;
  assign w_pwm_on  = (w_pwm_cur <= r_bright_q);

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_pwm_cnt  <= '0;
      r_bright_q <= '1;
    end else begin
      r_pwm_cnt <= w_blank ? w_pwm_cur : w_pwm_cur + 1'b1;
      if (w_frame_end) r_bright_q <= brightness;
    end
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_row_onehot = ROWS'(1) << w_row_idx;
  assign w_row_bits   = r_shadow[int'(w_row_idx)*COLS +: COLS];

  // Row and column are registered together from the same shadow and counter snapshot.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_slot_start && (w_row_idx == '0);
      if (!w_blank && w_pwm_on) begin
        row <= w_row_onehot;
        col <= ~w_row_bits;
      end else begin
        row <= '0;
        col <= '1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: edge-indexed reference model plus directed timing checks.
module tb_led_matrix_scanner;

`ifdef LED_SCAN_PWM_EN
  localparam int SD = 20;
  localparam int BL = 2;
`else
  localparam int SD = 4;
  localparam int BL = 1;
`endif
  localparam int R = 4;
  localparam int C = 4;
  localparam int P = R * SD;
  localparam int N = R * C;

  logic         system_clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] fb_in = '0;
  logic         fb_load = 1'b0;
  logic [R-1:0] row;
  logic [C-1:0] col;
  logic         frame_start;
`ifdef LED_SCAN_PWM_EN
  logic [3:0]   brightness = 4'd15;
`endif

  led_matrix_scanner #(
    .ROWS         (R),
    .COLS         (C),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .system_clk  (system_clk),
    .rst         (rst),
    .fb_in       (fb_in),
    .fb_load     (fb_load),
`ifdef LED_SCAN_PWM_EN
    .brightness  (brightness),
`endif
    .row         (row),
    .col         (col),
    .frame_start (frame_start)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: edges counted from the first non-reset edge.
  logic [N-1:0] m_shadow  = '0;
  logic [N-1:0] m_pending = '0;
  bit           m_pvalid  = 0;
  int           m_k       = 0;
  int           m_bq      = 15;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, m_k - 1);
    end
  endtask

  // One clock edge: capture inputs, advance, then compare outputs with the model.
  task automatic step();
    logic         ld, rs, lit, e_fs;
    logic [N-1:0] din;
    logic [R-1:0] e_row;
    logic [C-1:0] e_col;
    int           br, p, t, r;
    ld  = fb_load;
    rs  = rst;
    din = fb_in;
    br  = 15;
`ifdef LED_SCAN_PWM_EN
    br  = int'(brightness);
`endif
    @(posedge system_clk);
    #1;
    e_row = '0;
    e_col = '1;
    e_fs  = 1'b0;
    if (rs) begin
      m_shadow  = '0;
      m_pending = '0;
      m_pvalid  = 0;
      m_k       = 0;
      m_bq      = 15;
    end else begin
      if (m_k > 0) begin
        p    = m_k - 1;
        t    = p % SD;
        r    = (p / SD) % R;
        e_fs = (p % P == 0);
        lit  = (t >= BL);
        if (lit && (((t - BL) % 16) > m_bq)) lit = 1'b0;
        if (lit) begin
          e_row = R'(1) << r;
          e_col = ~m_shadow[r*C +: C];
        end
      end
      if (m_k > 0 && (m_k % P) == 0) begin
        if (m_pvalid) begin
          m_shadow = m_pending;
          m_pvalid = 0;
        end
        m_bq = br;
      end
      if (ld) begin
        m_pending = din;
        m_pvalid  = 1;
      end
      m_k++;
    end
    chk("row", 32'(row), 32'(e_row));
    chk("col", 32'(col), 32'(e_col));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 2000 && m_k <= k; i++) step();
  endtask

  task automatic load_at(input int k, input logic [N-1:0] v);
    run_to(k - 1);
    fb_in   = v;
    fb_load = 1'b1;
    run_to(k);
    fb_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_row", 32'(row), 32'h0);
    chk("reset_col", 32'(col), 32'hF);
    chk("reset_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;

`ifndef LED_SCAN_PWM_EN
    run_to(1);
    chk("first_fs_e1", 32'(frame_start), 32'h1);
    run_to(2);
    chk("first_row_e2", 32'(row), 32'h1);
    chk("first_col_e2", 32'(col), 32'hF);
    load_at(3, 16'hA5C3);
    chk("first_row_e3", 32'(row), 32'h1);
    run_to(4);
    chk("first_row_e4", 32'(row), 32'h1);
    run_to(5);
    chk("blank_row_e5", 32'(row), 32'h0);
    for (int e = 6; e <= 17; e++) begin
      run_to(e);
      chk("pre_swap_col", 32'(col), 32'hF);
    end
    run_to(18);
    chk("swap_row_e18", 32'(row), 32'h1);
    chk("swap_col_e18", 32'(col), 32'hC);
    load_at(20, 16'h1111);
    load_at(25, 16'hFFFF);
    run_to(30);
    chk("swap_row_e30", 32'(row), 32'h8);
    chk("swap_col_e30", 32'(col), 32'h5);
    run_to(34);
    chk("lww_col_e34", 32'(col), 32'h0);
    load_at(40, 16'h00FF);
    run_to(42);
    chk("lww_col_e42", 32'(col), 32'h0);
    load_at(48, 16'hFF00);
    run_to(50);
    chk("simul_col_e50", 32'(col), 32'h0);
    run_to(58);
    chk("simul_row_e58", 32'(row), 32'h4);
    chk("simul_col_e58", 32'(col), 32'hF);
    run_to(66);
    chk("simul_col_e66", 32'(col), 32'hF);
    run_to(74);
    chk("simul_col_e74", 32'(col), 32'h0);
    load_at(78, 16'h5A5A);
    run_to(83);
    rst = 1'b1;
    step();
    chk("midrst_row", 32'(row), 32'h0);
    chk("midrst_col", 32'(col), 32'hF);
    rst = 1'b0;
    run_to(18);
    chk("post_rst_row_e18", 32'(row), 32'h1);
    chk("post_rst_col_e18", 32'(col), 32'hF);
    run_to(34);
    chk("post_rst_col_e34", 32'(col), 32'hF);
`else
    brightness = 4'd3;
    load_at(5, 16'hFFFF);
    run_to(P);
    for (int s = 0; s < R; s++) begin
      int lit_cnt;
      lit_cnt = 0;
      for (int j = 0; j < SD; j++) begin
        run_to(P + 1 + s * SD + j);
        if (row != '0) lit_cnt++;
      end
      chk("pwm_lit_per_slot", 32'(lit_cnt), 32'd6);
    end
`endif

    for (int i = 0; i < 600; i++) begin
      fb_load = ($urandom_range(0, 7) == 0);
      fb_in   = N'($urandom);
`ifdef LED_SCAN_PWM_EN
      if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
`endif
      step();
    end
    fb_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
